mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: arbitration modes and index sizing.
package mem_arb_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Width of a channel index; at least one bit so single-channel builds stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or above start, wrapping past N-1 to 0.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter in front of a single-port synchronous RAM with one-cycle read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MODE     = MODE_RR
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    req,
    input  logic [CHANNELS-1:0]    we,
    input  logic [CHANNELS-1:0]    lock,
    input  logic [CHANNELS*AW-1:0] addr,
    input  logic [CHANNELS*DW-1:0] wdata,
    output logic [CHANNELS-1:0]    gnt,
    output logic [CHANNELS-1:0]    rvalid,
    output logic [DW-1:0]          rdata,
    output logic [AW-1:0]          mem_a,
    output logic [DW-1:0]          mem_d,
    output logic                   mem_w,
    input  logic [DW-1:0]          mem_q
);

    localparam int IW = idx_width(CHANNELS);

    logic [IW-1:0]       gidx;
    logic                any_gnt;
    logic [CHANNELS-1:0] rvalid_q;
    logic [DW-1:0]       rdata_q;

    if (CHANNELS == 1) begin : g_single
        always_comb begin
            gnt     = reset ? 1'b0 : req;
            gidx    = '0;
            any_gnt = gnt[0];
        end
    end else begin : g_multi
        logic [IW-1:0]       last_q;
        logic [IW-1:0]       start;
        logic [CHANNELS-1:0] pick_onehot;
        logic [IW-1:0]       pick_idx;
        logic                pick_found;
        logic                hold;

        always_comb begin
            if (MODE == MODE_FIXED || last_q == IW'(CHANNELS - 1)) begin
                start = '0;
            end else begin
                start = last_q + IW'(1);
            end
        end

        rr_pick #(
            .N  (CHANNELS),
            .IW (IW)
        ) u_pick (
            .req    (req),
            .start  (start),
            .onehot (pick_onehot),
            .idx    (pick_idx),
            .found  (pick_found)
        );

        // A locked owner that still requests keeps the port, whatever the mode.
        assign hold = lock[last_q] & req[last_q];

        always_comb begin
            gnt     = '0;
            gidx    = '0;
            any_gnt = 1'b0;
            if (!reset) begin
                if (hold) begin
                    gnt[last_q] = 1'b1;
                    gidx        = last_q;
                    any_gnt     = 1'b1;
                end else if (pick_found) begin
                    gnt     = pick_onehot;
                    gidx    = pick_idx;
                    any_gnt = 1'b1;
                end
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                last_q <= IW'(CHANNELS - 1);
            end else if (any_gnt) begin
                last_q <= gidx;
            end
        end
    end

    // gidx is 0 when idle, so the RAM sees channel 0's address and data.
    always_comb begin
        mem_a = addr[int'(gidx) * AW +: AW];
        mem_d = wdata[int'(gidx) * DW +: DW];
        mem_w = any_gnt & we[gidx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt & ~we;
            if (|rvalid_q) begin
                rdata_q <= mem_q;
            end
        end
    end

    // Masking with reset kills a read that was in flight when reset arrived.
    always_comb begin
        rvalid = reset ? '0 : rvalid_q;
        if (reset) begin
            rdata = '0;
        end else if (|rvalid_q) begin
            rdata = mem_q;
        end else begin
            rdata = rdata_q;
        end
    end

endmodule
